// File: rtl/one_hot_demux_pkg.sv
// Shared defaults and select-legality helper for the one-hot demux path.
package one_hot_demux_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_DEF   = 5;
  localparam int CNT_W_DEF = 16;

  // A zero select is never legal; multi-hot is legal only when checking is off.
  function automatic logic sel_legal(input logic is_zero, input logic is_onehot,
                                     input logic one_hot_check);
    return is_onehot | (~one_hot_check & ~is_zero);
  endfunction

endpackage

// File: rtl/one_hot_chk.sv
// Combinational select classifier: flags an all-zero select and an exactly-one-hot select.
module one_hot_chk
  import one_hot_demux_pkg::*;
#(
  parameter int CNT = CNT_DEF
) (
  input  logic [CNT-1:0] i_sel,
  output logic           o_is_zero,
  output logic           o_is_onehot
);

  logic [CNT-1:0] w_sel_m1;

  assign w_sel_m1    = i_sel - CNT'(1);
  assign o_is_zero   = (i_sel == '0);
  // Clearing the lowest set bit leaves zero only for a single-bit value.
  assign o_is_onehot = ~o_is_zero & ((i_sel & w_sel_m1) == '0);

endmodule

// File: rtl/one_hot_demux.sv
// One-stage valid/ready demux to CNT destinations by one-hot select.
// Illegal selects are consumed and dropped, with a sticky flag and saturating count.
module one_hot_demux
  import one_hot_demux_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int CNT           = CNT_DEF,
  parameter bit ONE_HOT_CHECK = 1'b0,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT-1:0]   in_sel,
  output logic [CNT-1:0]   out_vld,
  input  logic [CNT-1:0]   out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] drop_cnt
);

  logic             r_full;
  logic [CNT-1:0]   r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic [CNT_W-1:0] r_drop_cnt;

  logic w_is_zero;
  logic w_is_onehot;
  logic w_legal;
  logic w_ret;
  logic w_acc;
  logic w_load;
  logic w_drop;

  one_hot_chk #(.CNT(CNT)) u_chk (
    .i_sel       (in_sel),
    .o_is_zero   (w_is_zero),
    .o_is_onehot (w_is_onehot)
  );

  assign w_legal = sel_legal(w_is_zero, w_is_onehot, ONE_HOT_CHECK);
  assign w_ret   = r_full & |(r_sel & out_rdy);
  assign in_rdy  = ~r_full | w_ret;
  assign w_acc   = in_vld & in_rdy;
  assign w_load  = w_acc & w_legal;
  assign w_drop  = w_acc & ~w_legal;

  assign out_vld  = r_sel & {CNT{r_full}};
  assign out_data = r_data;
  assign err      = r_err;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_sel  <= '0;
      r_data <= '0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_sel  <= in_sel;
      r_data <= in_data;
    end else if (w_ret) begin
      r_full <= 1'b0;
    end
  end

  // A drop outranks a simultaneous clear so the event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_err <= 1'b1;
      if (err_clr)
        r_drop_cnt <= CNT_W'(1);
      else if (~&r_drop_cnt)
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_one_hot_demux.sv
// Directed bench for one_hot_demux; a second instance has the multi-hot check enabled.
module tb_one_hot_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_sel = '0;
  logic [4:0]  out_rdy = '0;
  logic        err_clr = 1'b0;

  logic        in_rdy, err, in_rdy_c, err_c;
  logic [4:0]  out_vld, out_vld_c;
  logic [31:0] out_data, out_data_c;
  logic [15:0] drop_cnt, drop_cnt_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  one_hot_demux #(.WIDTH(32), .CNT(5), .ONE_HOT_CHECK(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_sel(in_sel), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .err(err), .err_clr(err_clr), .drop_cnt(drop_cnt)
  );

  one_hot_demux #(.WIDTH(32), .CNT(5), .ONE_HOT_CHECK(1'b1), .CNT_W(16)) dut_chk (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_c), .in_data(in_data),
    .in_sel(in_sel), .out_vld(out_vld_c), .out_rdy(out_rdy), .out_data(out_data_c),
    .err(err_c), .err_clr(err_clr), .drop_cnt(drop_cnt_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_vld !== 5'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=%b", out_vld, 5'b0); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, 32'h0); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop_cnt got=%h exp=0", drop_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    in_vld = 1'b1; in_sel = 5'b00000; in_data = 32'h11; out_rdy = 5'b0;
    tick();
    in_sel = 5'b00100; in_data = 32'hAA;
    tick();
    in_vld = 1'b0;
    checks++; if (out_vld !== 5'b00100) begin failures++; $display("FAIL pre_rst_out_vld got=%b exp=%b", out_vld, 5'b00100); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL pre_rst_err got=%b exp=1", err); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_vld !== 5'b0) begin failures++; $display("FAIL async_rst_out_vld got=%b exp=%b", out_vld, 5'b0); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL async_rst_out_data got=%h exp=0", out_data); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL async_rst_in_rdy got=%b exp=1", in_rdy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL async_rst_err got=%b exp=0", err); end
    checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL async_rst_drop_cnt got=%h exp=0", drop_cnt); end
    #1 rst = 1'b0;
    tick();
    checks++; if (out_vld !== 5'b0) begin failures++; $display("FAIL post_rst_out_vld got=%b exp=%b", out_vld, 5'b0); end
  endtask

  task automatic test_streaming();
    out_rdy = 5'b11111; in_sel = 5'b00100;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin in_vld = 1'b1; in_data = i; end
      else in_vld = 1'b0;
      #1;
      if (i > 1) begin
        checks++; if (out_vld !== 5'b00100) begin failures++; $display("FAIL stream_vld beat=%0d got=%b exp=%b", i - 1, out_vld, 5'b00100); end
        checks++; if (out_data !== 32'(i - 1)) begin failures++; $display("FAIL stream_data got=%h exp=%h", out_data, 32'(i - 1)); end
      end
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL stream_in_rdy beat=%0d got=%b exp=1", i, in_rdy); end
      tick();
    end
    checks++; if (out_vld !== 5'b0) begin failures++; $display("FAIL stream_drain got=%b exp=%b", out_vld, 5'b0); end
  endtask

  task automatic test_backpressure();
    out_rdy = 5'b11011; in_sel = 5'b00100; in_vld = 1'b1; in_data = 32'hA5A5_0001;
    tick();
    in_data = 32'hB6B6_0002;
    repeat (3) begin
      #1;
      checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy got=%b exp=0", in_rdy); end
      checks++; if (out_data !== 32'hA5A5_0001) begin failures++; $display("FAIL bp_data_stable got=%h exp=%h", out_data, 32'hA5A5_0001); end
      checks++; if (out_vld !== 5'b00100) begin failures++; $display("FAIL bp_vld_stable got=%b exp=%b", out_vld, 5'b00100); end
      tick();
    end
    out_rdy = 5'b11111;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_in_rdy got=%b exp=1", in_rdy); end
    tick();
    in_vld = 1'b0;
    checks++; if (out_data !== 32'hB6B6_0002) begin failures++; $display("FAIL bp_next_beat got=%h exp=%h", out_data, 32'hB6B6_0002); end
    checks++; if (out_vld !== 5'b00100) begin failures++; $display("FAIL bp_next_vld got=%b exp=%b", out_vld, 5'b00100); end
    tick();
    checks++; if (out_vld !== 5'b0) begin failures++; $display("FAIL bp_drain got=%b exp=%b", out_vld, 5'b0); end
  endtask

  task automatic test_back_to_back();
    out_rdy = 5'b11111; in_vld = 1'b1;
    in_sel = 5'b00001; in_data = 32'hC0;
    tick();
    checks++; if (out_vld !== 5'b00001) begin failures++; $display("FAIL b2b_vld0 got=%b exp=%b", out_vld, 5'b00001); end
    in_sel = 5'b10000; in_data = 32'hC4;
    tick();
    in_vld = 1'b0;
    checks++; if (out_vld !== 5'b10000) begin failures++; $display("FAIL b2b_vld4 got=%b exp=%b", out_vld, 5'b10000); end
    checks++; if (out_data !== 32'hC4) begin failures++; $display("FAIL b2b_data got=%h exp=%h", out_data, 32'hC4); end
    tick();
  endtask

  task automatic test_illegal_zero();
    out_rdy = 5'b11111; in_sel = 5'b00000; in_vld = 1'b1; in_data = 32'h55;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL zero_in_rdy got=%b exp=1", in_rdy); end
    tick();
    checks++; if (out_vld !== 5'b0) begin failures++; $display("FAIL zero_out_vld got=%b exp=%b", out_vld, 5'b0); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL zero_err got=%b exp=1", err); end
    checks++; if (drop_cnt !== 16'h0001) begin failures++; $display("FAIL zero_drop_cnt got=%h exp=%h", drop_cnt, 16'h0001); end
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=%h", drop_cnt, 16'hFFFF); end
    tick();
    checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=%h", drop_cnt, 16'hFFFF); end
    in_vld = 1'b0;
  endtask

  task automatic test_err_clr();
    in_sel = 5'b00000; in_vld = 1'b1; err_clr = 1'b1;
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL clr_drop_err got=%b exp=1", err); end
    checks++; if (drop_cnt !== 16'h0001) begin failures++; $display("FAIL clr_drop_cnt got=%h exp=%h", drop_cnt, 16'h0001); end
    in_vld = 1'b0;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", err); end
    checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL clr_cnt got=%h exp=0", drop_cnt); end
  endtask

  task automatic test_multi_hot();
    out_rdy = 5'b00000; in_sel = 5'b00011; in_vld = 1'b1; in_data = 32'h3C;
    tick();
    in_vld = 1'b0;
    checks++; if (out_vld !== 5'b00011) begin failures++; $display("FAIL mh_vld got=%b exp=%b", out_vld, 5'b00011); end
    checks++; if (out_data !== 32'h3C) begin failures++; $display("FAIL mh_data got=%h exp=%h", out_data, 32'h3C); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mh_err got=%b exp=0", err); end
    checks++; if (out_vld_c !== 5'b0) begin failures++; $display("FAIL mh_chk_vld got=%b exp=%b", out_vld_c, 5'b0); end
    checks++; if (err_c !== 1'b1) begin failures++; $display("FAIL mh_chk_err got=%b exp=1", err_c); end
    checks++; if (drop_cnt_c !== 16'h0001) begin failures++; $display("FAIL mh_chk_cnt got=%h exp=%h", drop_cnt_c, 16'h0001); end
    out_rdy = 5'b11100;
    tick();
    checks++; if (out_vld !== 5'b00011) begin failures++; $display("FAIL mh_unsel_rdy got=%b exp=%b", out_vld, 5'b00011); end
    out_rdy = 5'b00010;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL mh_ret_in_rdy got=%b exp=1", in_rdy); end
    tick();
    checks++; if (out_vld !== 5'b0) begin failures++; $display("FAIL mh_retired got=%b exp=%b", out_vld, 5'b0); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_illegal_zero();
    test_err_clr();
    test_multi_hot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
